// File: rtl/mem_op_pkg.sv
// Shared definitions for the MEM-stage load/store unit: MIPS memory opcodes,
// access-size encoding, FSM state encoding and the opcode decoder.
package mem_op_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  // Size is log2 of the access width in bytes.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic      load;
    logic      store;
    mem_size_e size;
    logic      sgn;
  } mem_dec_t;

  // Non-memory opcodes decode to all-zero flags with byte size.
  function automatic mem_dec_t mem_decode(input logic [5:0] op);
    mem_dec_t d;
    d.load  = 1'b0;
    d.store = 1'b0;
    d.size  = SZ_B;
    d.sgn   = 1'b0;
    case (op)
      OP_LB:  begin d.load = 1'b1; d.sgn = 1'b1; end
      OP_LH:  begin d.load = 1'b1; d.size = SZ_H; d.sgn = 1'b1; end
      OP_LW:  begin d.load = 1'b1; d.size = SZ_W; end
      OP_LBU: begin d.load = 1'b1; end
      OP_LHU: begin d.load = 1'b1; d.size = SZ_H; end
      OP_SB:  begin d.store = 1'b1; end
      OP_SH:  begin d.store = 1'b1; d.size = SZ_H; end
      OP_SW:  begin d.store = 1'b1; d.size = SZ_W; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/grant/response bus between the load/store unit (master)
// and the memory system (slave).
interface mem_access_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_gnt;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_err;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/mem_load_align.sv
// Load data alignment: shifts the addressed lanes down to bit 0, truncates to
// the access size and sign- or zero-extends to 32 bits. Purely combinational.
module mem_load_align
  import mem_op_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  localparam int OFF_W = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [OFF_W-1:0]      i_off,
  input  mem_size_e             i_size,
  input  logic                  i_sgn,
  output logic [31:0]           o_result
);

  logic [DATA_WIDTH-1:0] w_shifted;

  // Shift by whole bytes, then extend according to the access size.
  always_comb begin
    w_shifted = i_rdata >> {i_off, 3'b000};
    o_result  = '0;
    case (i_size)
      SZ_B:    o_result = {{24{i_sgn & w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    o_result = {{16{i_sgn & w_shifted[15]}}, w_shifted[15:0]};
      default: o_result = w_shifted[31:0];
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: decodes the opcode, checks alignment, runs one
// request/grant/response transaction on the data bus and hands the extended
// result to writeback.
//
// Handshakes: a transfer happens on a clock edge where valid and ready are both
// high. in_valid/in_ready accept an operation (ready only in IDLE); out_valid
// holds with stable out_* until out_ready is seen; mem_req holds with stable
// mem_* until mem_gnt is seen; mem_rvalid (with mem_err) is sampled only while a
// request is outstanding.
module mem_access_unit
  import mem_op_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic                  out_misaligned,
  output logic                  out_err,
  output logic                  is_load,
  output logic                  is_store,
  output logic                  is_mem,
  output mem_state_e            dbg_state,
  mem_access_unit_if.master     mem
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  mem_state_e r_state, w_next;
  mem_dec_t   w_dec;
  logic       w_misaligned, w_accept, w_take_rsp, w_timeout, w_tmo_hit, w_enter_resp;
  logic [OFF_W-1:0]      w_off;
  logic [BE_W-1:0]       w_mask, w_be;
  logic [31:0]           w_word, w_load_data;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [CNT_W-1:0]      r_cnt;

  logic                  r_we, r_load, r_sgn;
  mem_size_e             r_size;
  logic [OFF_W-1:0]      r_off;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [BE_W-1:0]       r_mem_be;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [31:0]           r_out_data;
  logic                  r_out_err, r_out_mis;

  assign w_dec        = mem_decode(opcode);
  assign is_load      = w_dec.load;
  assign is_store     = w_dec.store;
  assign is_mem       = w_dec.load | w_dec.store;
  assign w_misaligned = ((w_dec.size == SZ_H) && addr[0]) ||
                        ((w_dec.size == SZ_W) && (addr[1:0] != 2'b00));
  assign w_off        = addr[OFF_W-1:0];
  assign w_mem_addr   = {addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign in_ready     = rst_n && (r_state == ST_IDLE);
  assign w_accept     = in_valid && in_ready;
  assign w_tmo_hit    = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_enter_resp = (r_state != ST_RESP) && (w_next == ST_RESP);

  // Byte enables and lane-replicated write data for the offered operation.
  always_comb begin
    w_mask = BE_W'(1);
    w_word = {4{store_data[7:0]}};
    case (w_dec.size)
      SZ_H: begin w_mask = BE_W'(2'b11);  w_word = {2{store_data[15:0]}}; end
      SZ_W: begin w_mask = BE_W'(4'hF);   w_word = store_data; end
      default: ;
    endcase
    w_be    = w_mask << w_off;
    w_wdata = {(DATA_WIDTH / 32){w_word}};
  end

  mem_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_rdata  (mem.mem_rdata),
    .i_off    (r_off),
    .i_size   (r_size),
    .i_sgn    (r_sgn),
    .o_result (w_load_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state; a response in the same cycle as the timeout wins over it.
  always_comb begin
    w_next     = r_state;
    w_take_rsp = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!is_mem || w_misaligned) w_next = ST_RESP;
          else                         w_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem.mem_gnt && mem.mem_rvalid) begin
          w_next = ST_RESP; w_take_rsp = 1'b1;
        end else if (w_tmo_hit) begin
          w_next = ST_RESP; w_timeout = 1'b1;
        end else if (mem.mem_gnt) begin
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem.mem_rvalid) begin
          w_next = ST_RESP; w_take_rsp = 1'b1;
        end else if (w_tmo_hit) begin
          w_next = ST_RESP; w_timeout = 1'b1;
        end
      end
      ST_RESP: begin
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Timeout counter: runs while a request is outstanding, clear otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       r_cnt <= '0;
    else if (r_state == ST_REQ || r_state == ST_WAIT) r_cnt <= r_cnt + CNT_W'(1);
    else                                              r_cnt <= '0;
  end

  // Latch the operation and its prepared bus fields on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we <= 1'b0; r_load <= 1'b0; r_sgn <= 1'b0; r_size <= SZ_B; r_off <= '0;
      r_mem_addr <= '0; r_mem_be <= '0; r_mem_wdata <= '0;
    end else if (w_accept) begin
      r_we        <= w_dec.store;
      r_load      <= w_dec.load;
      r_sgn       <= w_dec.sgn;
      r_size      <= w_dec.size;
      r_off       <= w_off;
      r_mem_addr  <= w_mem_addr;
      r_mem_be    <= w_be;
      r_mem_wdata <= w_wdata;
    end
  end

  // Result registers: loaded on entry to RESP, zeroed when the result leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0; r_out_err <= 1'b0; r_out_mis <= 1'b0;
    end else if (w_enter_resp) begin
      r_out_data <= (w_take_rsp && r_load) ? w_load_data : 32'd0;
      r_out_err  <= w_timeout | (w_take_rsp & mem.mem_err);
      r_out_mis  <= (r_state == ST_IDLE) && is_mem && w_misaligned;
    end else if (r_state == ST_RESP && out_ready) begin
      r_out_data <= '0; r_out_err <= 1'b0; r_out_mis <= 1'b0;
    end
  end

  assign mem.mem_req    = (r_state == ST_REQ);
  assign mem.mem_we     = r_we;
  assign mem.mem_addr   = r_mem_addr;
  assign mem.mem_be     = r_mem_be;
  assign mem.mem_wdata  = r_mem_wdata;
  assign out_valid      = (r_state == ST_RESP);
  assign out_data       = r_out_data;
  assign out_err        = r_out_err;
  assign out_misaligned = r_out_mis;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized operations
// checked against a byte-arithmetic model of the load/store rules.
module tb_mem_access_unit;
  import mem_op_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 8;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [5:0]  opcode = 6'h00;
  logic [31:0] addr = '0, store_data = '0, out_data;
  logic        out_misaligned, out_err, is_load, is_store, is_mem;
  mem_state_e  dbg_state;

  mem_access_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_access_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .addr(addr), .store_data(store_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_misaligned(out_misaligned), .out_err(out_err),
    .is_load(is_load), .is_store(is_store), .is_mem(is_mem),
    .dbg_state(dbg_state), .mem(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_q[$];

  initial begin
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_err = 1'b0;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int op_bytes(input logic [5:0] op);
    case (op)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      6'h23, 6'h2b:        return 4;
      default:             return 0;
    endcase
  endfunction
  function automatic bit op_load(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction
  function automatic bit op_store(input logic [5:0] op);
    return op inside {6'h28, 6'h29, 6'h2b};
  endfunction
  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] a);
    int n = op_bytes(op);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction
  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] sd);
    logic [31:0] r;
    int n = op_bytes(op);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'((sd >> (8 * (i % n))) & 32'hFF);
    return r;
  endfunction
  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] rd);
    int n = op_bytes(op);
    longint v = longint'(rd) >> (8 * (a % 4));
    longint full = longint'(1) << (8 * n);
    v = v % full;
    if ((op == 6'h20 || op == 6'h21) && v >= full / 2) v = v - full;
    return 32'(v);
  endfunction

  // ---------------- driver: one operation plus bus responder ----------------
  logic [3:0]  ob_be;
  logic        ob_we, ob_err, ob_mis, ob_ready, ob_unstable;
  logic [31:0] ob_addr, ob_wdata, ob_data;
  int          ob_req, ob_lat, ob_acc_cyc;
  bit          ob_done;

  task automatic do_op(input logic [5:0] op, input logic [31:0] a, sd, rd,
                       input logic er, input int gd, rdl, input bit ack);
    int gcnt = 0, rcnt = 0;
    bit granted = 0, responded = 0;
    ob_req = 0; ob_lat = -1; ob_done = 0; ob_unstable = 0;
    ob_be = '0; ob_we = 0; ob_addr = '0; ob_wdata = '0; ob_data = '0; ob_err = 0; ob_mis = 0;
    opcode = op; addr = a; store_data = sd; in_valid = 1'b1;
    ob_ready = in_ready; ob_acc_cyc = cyc;
    tick();
    in_valid = 1'b0; opcode = 6'($urandom); addr = $urandom; store_data = $urandom;
    for (int c = 1; c <= 40; c++) begin
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0; bus.mem_rdata = $urandom;
      if (out_valid) begin
        ob_lat = c; ob_data = out_data; ob_err = out_err; ob_mis = out_misaligned; ob_done = 1;
        break;
      end
      if (bus.mem_req) begin
        if (ob_req == 0) begin
          ob_be = bus.mem_be; ob_we = bus.mem_we; ob_addr = bus.mem_addr; ob_wdata = bus.mem_wdata;
        end else if ({ob_be, ob_we, ob_addr, ob_wdata} !==
                     {bus.mem_be, bus.mem_we, bus.mem_addr, bus.mem_wdata}) begin
          ob_unstable = 1;
        end
        ob_req++;
        if (gcnt == gd) begin
          bus.mem_gnt = 1'b1; granted = 1;
          if (rdl == 0) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = rd; bus.mem_err = er; responded = 1;
          end
        end
        gcnt++;
      end else if (granted && !responded) begin
        if (rcnt == rdl - 1) begin
          bus.mem_rvalid = 1'b1; bus.mem_rdata = rd; bus.mem_err = er; responded = 1;
        end
        rcnt++;
      end
      tick();
    end
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_err = 1'b0;
    if (ob_done && ack) begin
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; opcode = OP_LW; addr = 32'h1004;
    repeat (3) tick();
    n_tests++; if ({in_ready, bus.mem_req, out_valid, out_err, out_misaligned} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000",
                         {in_ready, bus.mem_req, out_valid, out_err, out_misaligned}); end
    n_tests++; if ({out_data, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.mem_we} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%h/%h expected all 0",
                         out_data, bus.mem_addr, bus.mem_be, bus.mem_wdata); end
    n_tests++; if ({is_load, is_store, is_mem} !== 3'b101) begin
      n_fail++; $display("FAIL reset_decode: got %b expected 101", {is_load, is_store, is_mem}); end
    in_valid = 1'b0; rst_n = 1'b1;
    tick();
    n_tests++; if (in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_release: got in_ready=%b state=%0d expected 1/0",
                         in_ready, dbg_state); end
  endtask

  task automatic test_decode();
    for (int o = 0; o < 64; o++) begin
      logic [2:0] e;
      opcode = 6'(o); #1;
      e = {op_load(6'(o)), op_store(6'(o)), op_bytes(6'(o)) != 0};
      n_tests++; if ({is_load, is_store, is_mem} !== e) begin
        n_fail++; $display("FAIL decode_%02h: got %b expected %b", o, {is_load, is_store, is_mem}, e); end
    end
    tick();
  endtask

  task automatic test_lw();
    do_op(OP_LW, 32'h1004, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1, 1);
    n_tests++; if ({ob_be, ob_we, ob_addr} !== {4'b1111, 1'b0, 32'h1004}) begin
      n_fail++; $display("FAIL lw_bus: got be=%b we=%b addr=%h expected 1111/0/00001004",
                         ob_be, ob_we, ob_addr); end
    n_tests++; if (ob_data !== 32'hDEADBEEF || ob_err !== 1'b0) begin
      n_fail++; $display("FAIL lw_data: got %h err=%b expected deadbeef err=0", ob_data, ob_err); end
    n_tests++; if (ob_lat !== 3 || ob_ready !== 1'b1) begin
      n_fail++; $display("FAIL lw_latency: got %0d ready=%b expected 3 ready=1", ob_lat, ob_ready); end
  endtask

  task automatic test_lb_lbu();
    do_op(OP_LB, 32'h1003, 32'h0, 32'h80FFFFFF, 1'b0, 0, 1, 1);
    n_tests++; if (ob_be !== 4'b1000 || ob_data !== 32'hFFFFFF80) begin
      n_fail++; $display("FAIL lb: got be=%b data=%h expected 1000/ffffff80", ob_be, ob_data); end
    do_op(OP_LBU, 32'h1003, 32'h0, 32'h80FFFFFF, 1'b0, 2, 2, 1);
    n_tests++; if (ob_be !== 4'b1000 || ob_data !== 32'h00000080) begin
      n_fail++; $display("FAIL lbu: got be=%b data=%h expected 1000/00000080", ob_be, ob_data); end
  endtask

  task automatic test_sh();
    do_op(OP_SH, 32'h2002, 32'h1234ABCD, 32'hFFFFFFFF, 1'b0, 1, 1, 1);
    n_tests++; if ({ob_we, ob_be, ob_wdata, ob_addr} !== {1'b1, 4'b1100, 32'hABCDABCD, 32'h2000}) begin
      n_fail++; $display("FAIL sh_bus: got we=%b be=%b wdata=%h addr=%h expected 1/1100/abcdabcd/00002000",
                         ob_we, ob_be, ob_wdata, ob_addr); end
    n_tests++; if ({ob_data, ob_err, ob_mis} !== 34'b0 || !ob_done) begin
      n_fail++; $display("FAIL sh_result: got data=%h err=%b mis=%b done=%0d expected 0/0/0/1",
                         ob_data, ob_err, ob_mis, ob_done); end
  endtask

  task automatic test_misaligned_nonmem();
    do_op(OP_LH, 32'h3001, 32'h0, 32'h0, 1'b0, 0, 1, 1);
    n_tests++; if (ob_mis !== 1'b1 || ob_lat !== 1 || ob_req !== 0 || ob_err !== 1'b0) begin
      n_fail++; $display("FAIL lh_misaligned: got mis=%b lat=%0d req=%0d err=%b expected 1/1/0/0",
                         ob_mis, ob_lat, ob_req, ob_err); end
    do_op(6'h00, 32'h3000, 32'h0, 32'h0, 1'b0, 0, 1, 1);
    n_tests++; if ({ob_mis, ob_err, ob_data} !== 34'b0 || ob_lat !== 1 || ob_req !== 0) begin
      n_fail++; $display("FAIL nonmem: got mis=%b err=%b data=%h lat=%0d req=%0d expected 0/0/0/1/0",
                         ob_mis, ob_err, ob_data, ob_lat, ob_req); end
  endtask

  task automatic test_same_cycle_and_err();
    do_op(OP_LHU, 32'h0000_7006, 32'h0, 32'h8001_2345, 1'b0, 0, 0, 1);
    n_tests++; if (ob_lat !== 2 || ob_data !== 32'h0000_8001) begin
      n_fail++; $display("FAIL gnt_rvalid_same: got lat=%0d data=%h expected 2/00008001", ob_lat, ob_data); end
    do_op(OP_SW, 32'h0000_7008, 32'h5555_AAAA, 32'h0, 1'b1, 1, 2, 1);
    n_tests++; if (ob_err !== 1'b1 || ob_data !== 32'h0) begin
      n_fail++; $display("FAIL bus_err: got err=%b data=%h expected 1/0", ob_err, ob_data); end
  endtask

  task automatic test_timeout();
    do_op(OP_LW, 32'h4000, 32'h0, 32'h0, 1'b0, -1, 0, 0);
    n_tests++; if (ob_req !== TMO || ob_lat !== TMO + 1) begin
      n_fail++; $display("FAIL timeout_len: got req=%0d lat=%0d expected %0d/%0d", ob_req, ob_lat, TMO, TMO + 1); end
    n_tests++; if (ob_err !== 1'b1 || ob_data !== 32'h0) begin
      n_fail++; $display("FAIL timeout_err: got err=%b data=%h expected 1/0", ob_err, ob_data); end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFFFFFF; bus.mem_err = 1'b0;
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_data !== 32'h0) begin
      n_fail++; $display("FAIL timeout_late_rvalid: got v=%b err=%b data=%h expected 1/1/0",
                         out_valid, out_err, out_data); end
    bus.mem_rvalid = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_gnt = 1'b1; tick();
    bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL idle_rvalid_ignored: got v=%b req=%b expected 0/0", out_valid, bus.mem_req); end
  endtask

  task automatic test_backpressure();
    do_op(OP_LW, 32'h5008, 32'h0, 32'h0BAD_F00D, 1'b0, 1, 2, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; opcode = OP_LW; addr = 32'h5100;
      n_tests++; if (out_valid !== 1'b1 || out_data !== 32'h0BAD_F00D || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL backpressure_%0d: got v=%b data=%h in_ready=%b expected 1/0badf00d/0",
                           i, out_valid, out_data, in_ready); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_tests++; if (out_valid !== 1'b0 || out_data !== 32'h0 || bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL backpressure_release: got v=%b data=%h req=%b expected 0/0/0",
                         out_valid, out_data, bus.mem_req); end
  endtask

  task automatic test_back_to_back();
    int acc[4];
    for (int i = 0; i < 4; i++) begin
      logic [31:0] rd = $urandom;
      do_op(OP_LW, 32'h100 + 32'(4 * i), 32'h0, rd, 1'b0, 0, 1, 1);
      acc[i] = ob_acc_cyc;
      n_tests++; if (ob_data !== rd || ob_lat !== 3) begin
        n_fail++; $display("FAIL b2b_data_%0d: got %h lat=%0d expected %h lat=3", i, ob_data, ob_lat, rd); end
    end
    for (int i = 1; i < 4; i++) begin
      n_tests++; if (acc[i] - acc[i-1] !== 4) begin
        n_fail++; $display("FAIL b2b_spacing_%0d: got %0d expected 4", i, acc[i] - acc[i-1]); end
    end
  endtask

  task automatic test_reset_mid();
    opcode = OP_LW; addr = 32'h6000; in_valid = 1'b1; tick(); in_valid = 1'b0;
    n_tests++; if (bus.mem_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_req_before: got %b expected 1", bus.mem_req); end
    rst_n = 1'b0; #1;
    n_tests++; if (bus.mem_req !== 1'b0 || out_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL rst_in_req: got req=%b v=%b state=%0d expected 0/0/0",
                         bus.mem_req, out_valid, dbg_state); end
    tick(); rst_n = 1'b1; tick();
    in_valid = 1'b1; tick(); in_valid = 1'b0; bus.mem_gnt = 1'b1; tick(); bus.mem_gnt = 1'b0;
    rst_n = 1'b0; #1;
    n_tests++; if (bus.mem_req !== 1'b0 || out_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL rst_in_wait: got req=%b v=%b state=%0d expected 0/0/0",
                         bus.mem_req, out_valid, dbg_state); end
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    tick(); rst_n = 1'b1; tick(); tick();
    n_tests++; if ({out_valid, bus.mem_req, out_data} !== 34'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_late_rsp: got v=%b req=%b data=%h rdy=%b expected 0/0/0/1",
                         out_valid, bus.mem_req, out_data, in_ready); end
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    do_op(OP_LBU, 32'h6001, 32'h0, 32'h0000AB00, 1'b0, 0, 1, 0);
    n_tests++; if (ob_data !== 32'h000000AB || !ob_done) begin
      n_fail++; $display("FAIL rst_resp_pre: got %h done=%0d expected 000000ab/1", ob_data, ob_done); end
    rst_n = 1'b0; #1;
    n_tests++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      n_fail++; $display("FAIL rst_in_resp: got v=%b data=%h expected 0/0", out_valid, out_data); end
    tick(); rst_n = 1'b1; tick();
  endtask

  task automatic test_random();
    logic [5:0] ops[9] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, 6'h00};
    for (int k = 0; k < 150; k++) begin
      logic [5:0]  op;
      logic [31:0] a, sd, rd, e;
      logic        er;
      int n, gd, rdl, e_lat, e_req;
      bit mis, memop;
      op = (k % 10 == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
      n = op_bytes(op);
      a = $urandom;
      if (n > 1 && $urandom_range(0, 3) != 0) a = a - (a % n);
      sd = $urandom; rd = $urandom; er = ($urandom_range(0, 7) == 0);
      gd = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
      memop = (n > 0);
      mis   = memop && (a % n) != 0;
      exp_q.push_back((memop && !mis && op_load(op)) ? m_load(op, a, rd) : 32'h0);
      e_lat = (!memop || mis) ? 1 : gd + 2 + rdl;
      e_req = (!memop || mis) ? 0 : gd + 1;
      do_op(op, a, sd, rd, er, gd, rdl, 1);
      e = exp_q.pop_front();
      n_tests++; if (ob_lat !== e_lat || ob_req !== e_req) begin
        n_fail++; $display("FAIL rnd_%0d_timing: op=%h got lat=%0d req=%0d expected %0d/%0d",
                           k, op, ob_lat, ob_req, e_lat, e_req); end
      n_tests++; if (ob_mis !== mis || ob_err !== (memop && !mis && er)) begin
        n_fail++; $display("FAIL rnd_%0d_flags: op=%h got mis=%b err=%b expected %b/%b",
                           k, op, ob_mis, ob_err, mis, memop && !mis && er); end
      if (!er) begin
        n_tests++; if (ob_data !== e) begin
          n_fail++; $display("FAIL rnd_%0d_data: op=%h addr=%h got %h expected %h", k, op, a, ob_data, e); end
      end
      if (memop && !mis) begin
        n_tests++; if (ob_be !== m_be(op, a) || ob_addr !== {a[31:2], 2'b00} ||
                       ob_we !== op_store(op) || ob_unstable) begin
          n_fail++; $display("FAIL rnd_%0d_bus: got be=%b addr=%h we=%b unstable=%b expected %b/%h/%b/0",
                             k, ob_be, ob_addr, ob_we, ob_unstable, m_be(op, a), {a[31:2], 2'b00}, op_store(op)); end
        if (op_store(op)) begin
          n_tests++; if (ob_wdata !== m_wdata(op, sd)) begin
            n_fail++; $display("FAIL rnd_%0d_wdata: got %h expected %h", k, ob_wdata, m_wdata(op, sd)); end
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_decode();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_misaligned_nonmem();
    test_same_cycle_and_err();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
